// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/reset sequencer for the stopwatch counter chain; button presses act one edge after sampling.
// Outputs change on the rising edge only, so they are settled before the falling-edge counter flops sample.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10,
  parameter int DIV_W    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic       tick_en,
  output logic       cnt_clr_n,
  output logic       disp_hold,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               cnt_clr_n_q, cnt_clr_n_d;
  logic               disp_hold_q, disp_hold_d;
  logic               ss_s, ss_q, lr_s, lr_q;
  logic               ss_press, lr_press, clear;
  logic               running;

  assign running = (state_q == RUN) || (state_q == LAP);

  always_comb begin
    ss_press    = ss_s & ~ss_q;
    // start/stop has priority; a coincident lap/reset press is dropped
    lr_press    = lr_s & ~lr_q & ~ss_press;
    state_d     = state_q;
    clear       = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_press)      state_d = RUN;
        else if (lr_press) clear   = 1'b1;
      end
      RUN: begin
        if (ss_press)      state_d = PAUSE;
        else if (lr_press) state_d = LAP;
      end
      LAP: begin
        if (ss_press)      state_d = PAUSE;
        else if (lr_press) state_d = RUN;
      end
      PAUSE: begin
        if (ss_press)      state_d = RUN;
        else if (lr_press) begin
          state_d = IDLE;
          clear   = 1'b1;
        end
      end
    endcase

    // Prescaler advances on the current state, so a pause keeps the partial period.
    div_cnt_d = div_cnt_q;
    if (running)
      div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + DIV_W'(1);
    if (state_d == IDLE || state_q == IDLE)
      div_cnt_d = '0;

    cnt_clr_n_d = ~clear;
    disp_hold_d = (state_d == LAP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      cnt_clr_n_q <= 1'b0;
      disp_hold_q <= 1'b0;
      ss_s        <= 1'b0;
      ss_q        <= 1'b0;
      lr_s        <= 1'b0;
      lr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      cnt_clr_n_q <= cnt_clr_n_d;
      disp_hold_q <= disp_hold_d;
      ss_s        <= btn_ss;
      ss_q        <= ss_s;
      lr_s        <= btn_lr;
      lr_q        <= lr_s;
    end
  end

  assign tick_en   = running && (div_cnt_q == LAST);
  assign cnt_clr_n = cnt_clr_n_q;
  assign disp_hold = disp_hold_q;
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: fixed vector table, directed corner sequences, then random buttons against a cycle model.
module tb_stopwatch_ctrl;
  localparam int TD = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic       tick_en, cnt_clr_n, disp_hold;
  logic [1:0] state;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TD), .DIV_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_ss    (btn_ss),
    .btn_lr    (btn_lr),
    .tick_en   (tick_en),
    .cnt_clr_n (cnt_clr_n),
    .disp_hold (disp_hold),
    .state     (state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: state as 0..3, elapsed running cycles modulo TD, transition table.
  int m_st, m_run;
  bit m_clr_n, m_ss_s, m_ss_p, m_lr_s, m_lr_p;
  int next_tbl [4][2];

  typedef struct {
    bit ss;
    bit lr;
    int st;
    bit tick;
    bit hold;
    bit clr_n;
  } vec_t;
  vec_t vecs [16];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_tick();
    return (m_st == 1 || m_st == 3) && (m_run == TD - 1);
  endfunction

  task automatic model_reset();
    m_st = 0; m_run = 0; m_clr_n = 0;
    m_ss_s = 0; m_ss_p = 0; m_lr_s = 0; m_lr_p = 0;
  endtask

  task automatic model_edge();
    bit pss, plr;
    int old;
    pss = m_ss_s && !m_ss_p;
    plr = m_lr_s && !m_lr_p && !pss;
    old = m_st;
    if (old == 1 || old == 3) m_run = (m_run + 1) % TD;
    m_clr_n = 1;
    if (pss) m_st = next_tbl[old][0];
    else if (plr) begin
      m_st = next_tbl[old][1];
      if (old == 0 || old == 2) m_clr_n = 0;
    end
    if (m_st == 0 || (old == 0 && m_st == 1)) m_run = 0;
    m_ss_p = m_ss_s; m_ss_s = btn_ss;
    m_lr_p = m_lr_s; m_lr_s = btn_lr;
  endtask

  task automatic compare_all();
    chk("state", int'(state), m_st);
    chk("tick_en", int'(tick_en), int'(m_tick()));
    chk("disp_hold", int'(disp_hold), int'(m_st == 3));
    chk("cnt_clr_n", int'(cnt_clr_n), int'(m_clr_n));
  endtask

  // Called at a falling edge; drives, takes one rising edge, checks, returns at the next falling edge.
  task automatic cycle(input bit ss, input bit lr);
    btn_ss = ss;
    btn_lr = lr;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic do_reset(input bit hold_ss);
    #1;
    reset_n = 1'b0;
    btn_ss  = hold_ss;
    btn_lr  = 1'b0;
    model_reset();
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_tick", int'(tick_en), 0);
    chk("rst_hold", int'(disp_hold), 0);
    chk("rst_clr_n", int'(cnt_clr_n), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int first, ticks;
    next_tbl[0][0] = 1; next_tbl[0][1] = 0;
    next_tbl[1][0] = 2; next_tbl[1][1] = 3;
    next_tbl[2][0] = 1; next_tbl[2][1] = 0;
    next_tbl[3][0] = 2; next_tbl[3][1] = 1;

    //           ss lr st tick hold clr_n
    vecs[0]  = '{0, 0, 0, 0, 0, 1};
    vecs[1]  = '{1, 0, 0, 0, 0, 1};
    vecs[2]  = '{0, 0, 1, 0, 0, 1};
    vecs[3]  = '{0, 1, 1, 0, 0, 1};
    vecs[4]  = '{0, 0, 3, 0, 1, 1};
    vecs[5]  = '{0, 1, 3, 0, 1, 1};
    vecs[6]  = '{0, 1, 1, 0, 0, 1};
    vecs[7]  = '{0, 0, 1, 0, 0, 1};
    vecs[8]  = '{1, 0, 1, 0, 0, 1};
    vecs[9]  = '{0, 0, 2, 0, 0, 1};
    vecs[10] = '{0, 1, 2, 0, 0, 1};
    vecs[11] = '{0, 0, 0, 0, 0, 0};
    vecs[12] = '{0, 0, 0, 0, 0, 1};
    vecs[13] = '{0, 1, 0, 0, 0, 1};
    vecs[14] = '{0, 0, 0, 0, 0, 0};
    vecs[15] = '{0, 0, 0, 0, 0, 1};

    model_reset();
    @(negedge clk);
    do_reset(0);

    foreach (vecs[i]) begin
      btn_ss = vecs[i].ss;
      btn_lr = vecs[i].lr;
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("vec%0d_state", i), int'(state), vecs[i].st);
      chk($sformatf("vec%0d_tick", i), int'(tick_en), int'(vecs[i].tick));
      chk($sformatf("vec%0d_hold", i), int'(disp_hold), int'(vecs[i].hold));
      chk($sformatf("vec%0d_clr_n", i), int'(cnt_clr_n), int'(vecs[i].clr_n));
      @(negedge clk);
    end

    // Idle for 50 cycles: no ticks.
    ticks = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(0, 0);
      if (tick_en) ticks++;
    end
    chk("idle_no_tick", ticks, 0);

    // Button held through reset gives one press; held for 30 cycles stays a single press.
    do_reset(1);
    cycle(1, 0);
    chk("held_rst_idle", int'(state), 0);
    cycle(1, 0);
    chk("held_rst_run", int'(state), 1);
    first = -1; ticks = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle(1, 0);
      if (tick_en) begin
        ticks++;
        if (first < 0) first = i;
      end
    end
    chk("first_tick_pos", first, TD - 1);
    chk("tick_count_30", ticks, 3);
    chk("held_single_press", int'(state), 1);

    // Pause on the wrap edge suppresses the tick; resume ticks at once.
    repeat (7) cycle(0, 0);
    cycle(1, 0);
    cycle(0, 0);
    chk("pause_state", int'(state), 2);
    chk("pause_suppress", int'(tick_en), 0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0);
      if (tick_en) ticks++;
    end
    chk("pause_no_ticks", ticks, 0);
    cycle(1, 0);
    cycle(0, 0);
    chk("resume_state", int'(state), 1);
    chk("resume_tick", int'(tick_en), 1);

    // Lap then stop from lap.
    cycle(0, 1);
    cycle(0, 0);
    chk("lap_state", int'(state), 3);
    chk("lap_hold", int'(disp_hold), 1);
    cycle(1, 0);
    cycle(0, 0);
    chk("lap_to_pause", int'(state), 2);
    chk("lap_pause_hold", int'(disp_hold), 0);

    // Reset-to-zero from pause, then a full period to the first tick.
    cycle(0, 1);
    cycle(0, 0);
    chk("zero_state", int'(state), 0);
    chk("zero_clr_low", int'(cnt_clr_n), 0);
    cycle(0, 0);
    chk("zero_clr_high", int'(cnt_clr_n), 1);
    cycle(1, 0);
    cycle(0, 0);
    first = -1;
    for (int i = 1; i <= 15; i++) begin
      cycle(0, 0);
      if (tick_en && first < 0) first = i;
    end
    chk("zero_first_tick", first, TD - 1);

    // Simultaneous presses: start/stop wins, lap/reset is lost.
    cycle(1, 1);
    cycle(0, 0);
    chk("simul_state", int'(state), 2);
    cycle(0, 0);
    chk("simul_lr_lost", int'(state), 2);

    // Asynchronous reset in the middle of a run.
    cycle(1, 0);
    cycle(0, 0);
    repeat (5) cycle(0, 0);
    chk("pre_async_run", int'(state), 1);
    do_reset(0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0)
        do_reset(bit'($urandom_range(0, 1)));
      else
        cycle(bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 5) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the stopwatch counter chain built from the negative-edge T/D flip-flop cells. It turns two debounced push-button levels into a four-state run/pause/lap/reset sequence. It produces the count-tick enable (drives the T inputs of the least-significant counter stage), the active-low clear that feeds the counter flip-flops' `reset_n`, and a display-hold flag for the lap readout. Controller state updates on the rising edge of `clk`, so every output is stable half a cycle before the counter flip-flops sample on the falling edge.

## Interface
- `TICK_DIV`, 10, number of `clk` cycles per count tick (10 × 1 ms = 10 ms centisecond tick); legal range 2 to 2^`DIV_W`.
- `DIV_W`, 4, width of the prescaler counter.

- `clk`  in  1  system clock; all controller registers update on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_ss`  in  1  start/stop button, debounced level, synchronous to `clk`.
- `btn_lr`  in  1  lap/reset button, debounced level, synchronous to `clk`.
- `tick_en`  out  1  one-cycle count-enable pulse to the counter chain.
- `cnt_clr_n`  out  1  active-low clear to the counter flip-flops' `reset_n`.
- `disp_hold`  out  1  high: the display latches freeze the shown value.
- `state`  out  2  current state: IDLE=00, RUN=01, PAUSE=10, LAP=11.

## Operation
- Input stage: each button passes through a sample register (`*_s`) and a previous-value register (`*_q`).
  - press = `*_s & ~*_q`, one cycle wide.
  - A held button produces exactly one press.
- FSM transitions, evaluated on a press:
  - IDLE: ss → RUN. lr → stay in IDLE and issue a clear pulse.
  - RUN: ss → PAUSE. lr → LAP.
  - LAP: ss → PAUSE. lr → RUN (lap released).
  - PAUSE: ss → RUN. lr → IDLE and issue a clear pulse.
- Simultaneous ss and lr presses in the same cycle: ss wins and lr is discarded.
- Prescaler `div_cnt`:
  - Increments each cycle in RUN or LAP and wraps from `TICK_DIV`-1 to 0.
  - Held in PAUSE, so the fractional period is preserved across a pause.
  - Forced to 0 on every entry to IDLE and on the IDLE→RUN transition.
- `tick_en` = (state is RUN or LAP) AND (`div_cnt` == `TICK_DIV`-1). It is decoded combinationally from registers only, never from the button inputs.
- Counting continues in LAP; only the display is frozen.
- `disp_hold` = 1 exactly while state is LAP. Entering PAUSE from LAP releases the hold, and PAUSE shows the live (stopped) count.
- `cnt_clr_n` is registered and goes low for exactly one cycle after each clear-pulse transition.
- Width rule: `div_cnt` is `DIV_W` bits and compares against `TICK_DIV`-1 truncated to `DIV_W`. `TICK_DIV` > 2^`DIV_W` is illegal.

## Timing
- Reset (`reset_n` low, asynchronous):
  - State IDLE, `div_cnt`=0, `tick_en`=0, `disp_hold`=0.
  - `cnt_clr_n`=0, which holds the counter chain cleared. It returns to 1 on the first rising edge after `reset_n` deasserts.
  - Button registers reset to 0, so a button held through reset registers a press one edge after release of reset.
- Press latency: button rises before edge k → `*_s`=1 after edge k → state changes at edge k+1.
- Clear pulse: for a clear-issuing press decoded at edge k+1, `cnt_clr_n` is low from edge k+1 to edge k+2.
- First tick after IDLE→RUN at edge k+1: `tick_en` is high in the cycle after edge k+1+(`TICK_DIV`-1). After that, one tick every `TICK_DIV` cycles.
- A press that leaves RUN/LAP for PAUSE on the same edge where `div_cnt` would wrap suppresses that tick, because `tick_en` follows the new state. On resume, the tick fires after the remaining 1 cycle.
- Reset mid-operation: immediate return to reset values; no tick is emitted after `reset_n` falls.

## Test plan
- Reset then idle: release `reset_n`, no buttons for 50 cycles → `state`=00, `tick_en` never 1, `cnt_clr_n` 0 until the first edge and then 1.
- Start/run: ss press at edge 10 → `state`=01 at edge 12. `tick_en` pulses at cycles 21, 31, 41 (`TICK_DIV`=10). Holding ss for 30 cycles gives one press only.
- Pause/resume: run, pause with `div_cnt`=6, wait 20 cycles, resume → first tick exactly 4 cycles after resume; no ticks in PAUSE.
- Lap: RUN, lr press → `state`=11, `disp_hold`=1, ticks continue. lr again → `state`=01, `disp_hold`=0. ss from LAP → `state`=10, `disp_hold`=0.
- Reset-to-zero: PAUSE, lr press → `state`=00, `cnt_clr_n` low for exactly one cycle, `div_cnt`=0. Next ss gives first tick after 10 cycles.
- Simultaneous presses and async reset: ss and lr rise together in RUN → `state`=10. Drop `reset_n` mid-cycle in RUN → outputs hit reset values with no clock edge.
